// File: rtl/sprite_line_buffer_v2.sv
// Double-buffered sprite line buffer: queued tile draws with X-flip and right-edge clipping,
// clear-behind scanout. Define SPRLB_FIRST_WINS_EN for first-opaque-wins drawing.
module sprite_line_buffer_v2 #(
  parameter int LINE_W     = 512,
  parameter int TILE_W     = 16,
  parameter int BPP        = 4,
  parameter int COLOR_W    = 7,
  parameter int FIFO_DEPTH = 4,
  localparam int XW        = $clog2(LINE_W) + 1
) (
  input  logic                      CLK_96M,
  input  logic                      reset,
  input  logic                      CE_PIX,
  input  logic                      LINE_START,
  input  logic                      NL,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [TILE_W*BPP-1:0]     wr_data,
  input  logic [COLOR_W-1:0]        wr_color,
  input  logic                      wr_prio,
  input  logic [XW-1:0]             wr_x,
  input  logic                      wr_flipx,
  output logic [COLOR_W+BPP-1:0]    pixel_out,
  output logic                      prio_out,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW  = $clog2(LINE_W);
  localparam int CW  = $clog2(TILE_W) + 1;
  localparam int EW  = 1 + COLOR_W + BPP;
  localparam int DW  = TILE_W * BPP;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int QW  = DW + COLOR_W + 1 + XW + 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAW} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   clr_cnt;
  logic            line_start_eff;

  // Two line buffers; entry = {prio, colour, pen}.
  logic [EW-1:0]   mem [2][LINE_W];
  logic            draw_sel;
  logic            disp_sel;
  logic [1:0]      buf_we;
  logic [AW-1:0]   buf_addr  [2];
  logic [EW-1:0]   buf_wdata [2];

  assign disp_sel       = ~draw_sel;
  assign line_start_eff = LINE_START & (state != ST_CLEAR);

  // Request FIFO. A request transfers on a cycle where wr_valid & wr_ready are both high;
  // wr_ready never depends on wr_valid, and the engine only sees an entry the cycle after.
  logic [QW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FAW:0]    wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, push, pop;
  logic [DW-1:0]   h_data;
  logic [COLOR_W-1:0] h_color;
  logic            h_prio, h_flip;
  logic [XW-1:0]   h_x;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) && (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);
  assign wr_ready   = ~fifo_full & ~LINE_START & (state != ST_CLEAR) & ~reset;
  assign push       = wr_valid & wr_ready;
  assign {h_data, h_color, h_prio, h_x, h_flip} = fifo_mem[rd_ptr[FAW-1:0]];

  always_ff @(posedge CLK_96M) begin
    if (push) fifo_mem[wr_ptr[FAW-1:0]] <= {wr_data, wr_color, wr_prio, wr_x, wr_flipx};
  end

  always_ff @(posedge CLK_96M) begin
    if (reset || line_start_eff) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Draw engine tile registers.
  logic [DW-1:0]      t_data;
  logic [COLOR_W-1:0] t_color;
  logic               t_prio, t_flip;
  logic [XW-1:0]      t_x;
  logic [CW-1:0]      cnt;
  logic               last_pix;

  assign last_pix = (cnt == CW'(TILE_W - 1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_CLEAR: if (clr_cnt == AW'(LINE_W - 1)) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty && !line_start_eff) begin
          pop      = 1'b1;
          state_nx = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (line_start_eff) begin
          state_nx = ST_IDLE;
        end else if (last_pix) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (pop) begin
        t_data  <= h_data;
        t_color <= h_color;
        t_prio  <= h_prio;
        t_x     <= h_x;
        t_flip  <= h_flip;
        cnt     <= '0;
      end else if (state == ST_DRAW) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Current draw pixel: source index honours X-flip, target is clipped at the right edge.
  logic [CW-1:0]  src_idx;
  logic [DW-1:0]  shifted;
  logic [BPP-1:0] pix_pen;
  logic [XW-1:0]  tgt;
  logic           draw_ok;
  logic           dr_we;
  logic [AW-1:0]  dr_addr;
  logic [EW-1:0]  dr_wdata;

  always_comb begin
    src_idx = t_flip ? (CW'(TILE_W - 1) - cnt) : cnt;
    shifted = t_data >> (32'(src_idx) * BPP);
    pix_pen = shifted[BPP-1:0];
    tgt     = t_x + XW'(cnt);
    draw_ok = (state == ST_DRAW) && !line_start_eff && (pix_pen != '0) && !tgt[XW-1];
  end

`ifdef SPRLB_FIRST_WINS_EN
  // Read-modify-write: stage 2 writes only if the target pen is still 0. A write
  // landing on the same edge as the stage-1 read is forwarded as "occupied".
  logic           s2_valid, s2_fwd;
  logic [AW-1:0]  s2_addr;
  logic [EW-1:0]  s2_wdata;
  logic [BPP-1:0] s2_cur_pen;

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_fwd   <= 1'b0;
    end else begin
      s2_valid <= draw_ok;
      s2_fwd   <= dr_we && (dr_addr == tgt[AW-1:0]);
    end
    s2_addr    <= tgt[AW-1:0];
    s2_wdata   <= {t_prio, t_color, pix_pen};
    s2_cur_pen <= mem[draw_sel][tgt[AW-1:0]][BPP-1:0];
  end

  assign dr_we    = s2_valid & ~line_start_eff & ~s2_fwd & (s2_cur_pen == '0);
  assign dr_addr  = s2_addr;
  assign dr_wdata = s2_wdata;
`else
  assign dr_we    = draw_ok;
  assign dr_addr  = tgt[AW-1:0];
  assign dr_wdata = {t_prio, t_color, pix_pen};
`endif

  // Scanout: read at CE_PIX, clear the same location on the next cycle.
  logic [XW-1:0]  scan_pos;
  logic [AW-1:0]  scan_addr;
  logic           scan_go, scan_rd;
  logic [EW-1:0]  scan_data;
  logic           ce_q, rd_q;
  logic           clr_pend, clr_sel;
  logic [AW-1:0]  clr_addr;

  assign scan_go   = CE_PIX & ~LINE_START & (state != ST_CLEAR);
  assign scan_rd   = scan_go & ~scan_pos[XW-1];
  assign scan_addr = NL ? (AW'(LINE_W - 1) - scan_pos[AW-1:0]) : scan_pos[AW-1:0];

  always_ff @(posedge CLK_96M) begin
    if (scan_rd) scan_data <= mem[disp_sel][scan_addr];
    clr_addr <= scan_addr;
    clr_sel  <= disp_sel;
  end

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      scan_pos  <= '0;
      draw_sel  <= 1'b0;
      clr_pend  <= 1'b0;
      ce_q      <= 1'b0;
      rd_q      <= 1'b0;
      pixel_out <= '0;
      prio_out  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun  <= line_start_eff & (~fifo_empty | (state == ST_DRAW));
      clr_pend <= scan_rd;
      ce_q     <= scan_go;
      rd_q     <= scan_rd;
      if (line_start_eff) begin
        draw_sel <= ~draw_sel;
        scan_pos <= '0;
      end else if (scan_rd) begin
        scan_pos <= scan_pos + 1'b1;
      end
      if (state == ST_CLEAR) begin
        {prio_out, pixel_out} <= '0;
      end else if (ce_q) begin
        {prio_out, pixel_out} <= rd_q ? scan_data : '0;
      end
    end
  end

  // Per-buffer write port: reset clear, then clear-behind, then draw. Clear-behind and
  // draw never hit the same buffer, since draws are suppressed on the swap cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      buf_we[b]    = 1'b0;
      buf_addr[b]  = '0;
      buf_wdata[b] = '0;
      if (state == ST_CLEAR) begin
        buf_we[b]   = 1'b1;
        buf_addr[b] = clr_cnt;
      end else if (clr_pend && (clr_sel == 1'(b))) begin
        buf_we[b]   = 1'b1;
        buf_addr[b] = clr_addr;
      end else if (dr_we && (draw_sel == 1'(b))) begin
        buf_we[b]    = 1'b1;
        buf_addr[b]  = dr_addr;
        buf_wdata[b] = dr_wdata;
      end
    end
  end

  always_ff @(posedge CLK_96M) begin
    for (int b = 0; b < 2; b++) begin
      if (buf_we[b]) mem[b][buf_addr[b]] <= buf_wdata[b];
    end
  end

  assign busy = ~fifo_empty | (state == ST_DRAW);

endmodule

// File: tb/tb_sprite_line_buffer_v2.sv
// Bench for sprite_line_buffer_v2: directed tiles, scanout checked through an expected queue.
module tb_sprite_line_buffer_v2;

  localparam int LINE_W  = 512;
  localparam int TILE_W  = 16;
  localparam int BPP     = 4;
  localparam int COLOR_W = 7;
  localparam int XW      = 10;
  localparam int EW      = 12;

  logic                   CLK_96M = 1'b0;
  logic                   reset = 1'b1;
  logic                   CE_PIX = 1'b0;
  logic                   LINE_START = 1'b0;
  logic                   NL = 1'b0;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic [TILE_W*BPP-1:0]  wr_data = '0;
  logic [COLOR_W-1:0]     wr_color = '0;
  logic                   wr_prio = 1'b0;
  logic [XW-1:0]          wr_x = '0;
  logic                   wr_flipx = 1'b0;
  logic [COLOR_W+BPP-1:0] pixel_out;
  logic                   prio_out;
  logic                   busy;
  logic                   overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  logic [EW-1:0] exp_q [$];
  int            idx_q [$];
  logic [EW-1:0] exp_img [LINE_W];
  logic          ce_d1 = 1'b0;
  logic          ce_d2 = 1'b0;

  sprite_line_buffer_v2 dut (
    .CLK_96M(CLK_96M), .reset(reset), .CE_PIX(CE_PIX), .LINE_START(LINE_START), .NL(NL),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_color(wr_color),
    .wr_prio(wr_prio), .wr_x(wr_x), .wr_flipx(wr_flipx), .pixel_out(pixel_out),
    .prio_out(prio_out), .busy(busy), .overrun(overrun)
  );

  // Clock and cycle counter
  always #5 CLK_96M = ~CLK_96M;

  always @(posedge CLK_96M) begin
    cyc   <= cyc + 1;
    ce_d2 <= ce_d1;
    ce_d1 <= CE_PIX & ~LINE_START & ~reset;
  end

  // Monitor: scanned pixel is presented two edges after its CE_PIX
  always @(negedge CLK_96M) begin
    logic [EW-1:0] e;
    int            ix;
    if (overrun) ovr_cnt++;
    if (ce_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scan_unexpected got=%h exp=<none>", {prio_out, pixel_out});
      end else begin
        e  = exp_q.pop_front();
        ix = idx_q.pop_front();
        if ({prio_out, pixel_out} !== e) begin
          failures++;
          $display("FAIL scan_pixel idx=%0d got=%h exp=%h", ix, {prio_out, pixel_out}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [TILE_W*BPP-1:0] fill(input logic [BPP-1:0] pen);
    return {TILE_W{pen}};
  endfunction

  // Driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge CLK_96M); #1;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    step();
    if (chk) begin
      @(negedge CLK_96M);
      check("rst_pixel", pixel_out, 0);
      check("rst_prio", prio_out, 0);
      check("rst_ready", wr_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic send_tile(input logic [XW-1:0] x, input logic [TILE_W*BPP-1:0] d,
                           input logic [COLOR_W-1:0] c, input bit p, input bit f,
                           output int acc);
    wr_valid = 1'b1; wr_x = x; wr_data = d; wr_color = c; wr_prio = p; wr_flipx = f;
    acc = -1;
    for (int k = 0; k < 300 && acc < 0; k++) begin
      @(negedge CLK_96M);
      if (wr_ready) acc = cyc;
      step();
    end
    wr_valid = 1'b0;
    if (acc < 0) check("send_timeout", 1, 0);
  endtask

  task automatic wait_idle(output int at);
    at = -1;
    for (int k = 0; k < 400 && at < 0; k++) begin
      @(negedge CLK_96M);
      if (!busy) at = cyc;
      step();
    end
    if (at < 0) check("idle_timeout", 1, 0);
  endtask

  task automatic line_start();
    LINE_START = 1'b1;
    step();
    LINE_START = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < LINE_W; i++) exp_img[i] = '0;
  endtask

  task automatic scan_line(input bit nl, input int gap, input int extra);
    NL = nl;
    for (int i = 0; i < LINE_W + extra; i++) begin
      CE_PIX = 1'b1;
      exp_q.push_back((i < LINE_W) ? exp_img[nl ? LINE_W-1-i : i] : 12'h000);
      idx_q.push_back(i);
      step();
      CE_PIX = 1'b0;
      repeat (gap) step();
    end
    repeat (3) step();
  endtask

  initial begin
    int early;
    int t;
    int acc [6];
    int ovr0;

    // Reset, restart mid-clear, then time the clear
    do_reset(1'b1);
    repeat (100) step();
    do_reset(1'b0);
    early = 0;
    for (int k = 0; k < LINE_W; k++) begin
      @(negedge CLK_96M);
      if (wr_ready) early++;
      step();
    end
    check("clear_ready_early", early, 0);
    @(negedge CLK_96M);
    check("ready_after_clear", wr_ready, 1);
    step();

    clear_img();
    scan_line(1'b0, 0, 0);

    // Plain and flipped tile at x=100
    send_tile(10'd100, 64'h0000_0000_0000_1234, 7'h15, 1'b1, 1'b0, t);
    wait_idle(t);
    line_start();
    clear_img();
    exp_img[100] = {1'b1, 7'h15, 4'h4};
    exp_img[101] = {1'b1, 7'h15, 4'h3};
    exp_img[102] = {1'b1, 7'h15, 4'h2};
    exp_img[103] = {1'b1, 7'h15, 4'h1};
    scan_line(1'b0, 1, 0);

    send_tile(10'd100, 64'h0000_0000_0000_1234, 7'h15, 1'b1, 1'b1, t);
    wait_idle(t);
    line_start();
    clear_img();
    exp_img[115] = {1'b1, 7'h15, 4'h4};
    exp_img[114] = {1'b1, 7'h15, 4'h3};
    exp_img[113] = {1'b1, 7'h15, 4'h2};
    exp_img[112] = {1'b1, 7'h15, 4'h1};
    scan_line(1'b0, 0, 0);

    // Right-edge clip, CE past end of line, then clear-behind after two swaps
    send_tile(10'd505, fill(4'hF), 7'h2A, 1'b0, 1'b0, t);
    wait_idle(t);
    line_start();
    clear_img();
    for (int i = 505; i < LINE_W; i++) exp_img[i] = {1'b0, 7'h2A, 4'hF};
    scan_line(1'b0, 0, 2);
    clear_img();
    line_start();
    scan_line(1'b0, 0, 0);
    line_start();
    scan_line(1'b0, 0, 0);

    // Six back-to-back tiles: FIFO fills, no bubbles between tiles
    for (int k = 0; k < 6; k++)
      send_tile(10'(300 + 16*k), fill(4'(k + 1)), 7'(7'h40 + k), k[0], 1'b0, acc[k]);
    for (int k = 1; k < 5; k++) check("b2b_accept", acc[k] - acc[0], k);
    check("full_stall_accept", acc[5] - acc[0], 18);
    wait_idle(t);
    check("b2b_busy_drop", t - acc[0], 98);
    line_start();
    clear_img();
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 16; j++) exp_img[300 + 16*k + j] = {k[0], 7'(7'h40 + k), 4'(k + 1)};
    scan_line(1'b1, 0, 0);

    // Abort with queued work; a request coinciding with LINE_START is refused
    check("no_spurious_overrun", ovr_cnt, 0);
    send_tile(10'd0,  64'h0, 7'h01, 1'b0, 1'b0, t);
    send_tile(10'd20, fill(4'h7), 7'h02, 1'b0, 1'b0, t);
    send_tile(10'd40, fill(4'h7), 7'h03, 1'b0, 1'b0, t);
    send_tile(10'd60, fill(4'h7), 7'h04, 1'b0, 1'b0, t);
    LINE_START = 1'b1;
    wr_valid = 1'b1; wr_x = 10'd80; wr_data = fill(4'h3); wr_color = 7'h05; wr_flipx = 1'b0;
    @(negedge CLK_96M);
    check("ls_blocks_ready", wr_ready, 0);
    check("busy_before_abort", busy, 1);
    ovr0 = ovr_cnt;
    step();
    LINE_START = 1'b0;
    wr_valid = 1'b0;
    @(negedge CLK_96M);
    check("overrun_pulse", overrun, 1);
    check("busy_after_abort", busy, 0);
    step();
    repeat (3) step();
    check("overrun_once", ovr_cnt - ovr0, 1);
    clear_img();
    scan_line(1'b0, 0, 0);
    line_start();
    scan_line(1'b0, 0, 0);

    // Overlapping tiles at x=200, mirrored scan
    send_tile(10'd200, fill(4'h5), 7'h11, 1'b0, 1'b0, t);
    send_tile(10'd200, fill(4'h9), 7'h22, 1'b1, 1'b0, t);
    wait_idle(t);
    repeat (2) step();
    line_start();
    clear_img();
    for (int i = 200; i < 216; i++)
`ifdef SPRLB_FIRST_WINS_EN
      exp_img[i] = {1'b0, 7'h11, 4'h5};
`else
      exp_img[i] = {1'b1, 7'h22, 4'h9};
`endif
    scan_line(1'b1, 0, 0);

    repeat (4) step();
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
